// File: rtl/spi_master_param.sv
// -----------------------------------------------------------------------------
// spi_master_param
//   Parametrised SPI master for one external slave. Word width, SPI mode
//   (CPOL/CPHA), bit order and SCLK divider are set by parameters. Words can be
//   chained into a burst with chip select held low (cont=1).
//
//   Optional build macro: SPI_MASTER_LOOPBACK_EN
//     When defined, an extra 'loopback' input makes the receive path sample
//     the registered mosi instead of miso. The external pins toggle as usual.
//
// Ports
//   clk      system clock
//   rst      synchronous active-high reset
//   start    word request, accepted in IDLE or WAIT (not in the finish cycle)
//   cont     sampled with start; 1 keeps cs_n low after this word
//   tx_data  word to transmit, sampled with start
//   miso     serial data from the slave
//   loopback (macro only) 1 = receive from mosi instead of miso
//   sclk     serial clock, idles at CPOL
//   mosi     serial data to the slave
//   cs_n     active-low chip select
//   busy     high in SETUP, SHIFT, HOLD and TEARDOWN
//   finish   one-cycle pulse when rx_data is valid
//   rx_data  last received word, held until the next finish
// -----------------------------------------------------------------------------
module spi_master_param #(
  parameter int CLK_DIV   = 4,
  parameter int DATA_W    = 8,
  parameter int CPOL      = 0,
  parameter int CPHA      = 0,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cont,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              miso,
`ifdef SPI_MASTER_LOOPBACK_EN
  input  logic              loopback,
`endif
  output logic              sclk,
  output logic              mosi,
  output logic              cs_n,
  output logic              busy,
  output logic              finish,
  output logic [DATA_W-1:0] rx_data
);

  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int EDGE_W = $clog2(2*DATA_W+1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV-1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2*DATA_W);
  localparam logic              IDLE_SCLK = (CPOL != 0) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    SHIFT    = 3'd2,
    HOLD     = 3'd3,
    WAIT     = 3'd4,
    TEARDOWN = 3'd5
  } state_t;

  state_t              state_r;
  logic [DIV_W-1:0]    div_cnt_r;
  logic [EDGE_W-1:0]   edge_cnt_r;   // SCLK edges already produced in this word
  logic [DATA_W-1:0]   tx_r;
  logic [DATA_W-1:0]   rx_r;
  logic                cont_r;

  logic [EDGE_W-1:0]   next_edge_s;
  int                  drive_idx_s;
  logic                drive_bit_s;
  logic                first_bit_s;
  logic                sample_now_s;
  logic                drive_now_s;
  logic                rx_in_s;

  // Bit 'idx' of a word in transmission order (idx 0 goes out first).
  function automatic logic pick_bit(input logic [DATA_W-1:0] w, input int idx);
    logic [DATA_W-1:0] t;
    if (MSB_FIRST != 0) begin
      t = w << idx;
      pick_bit = t[DATA_W-1];
    end else begin
      t = w >> idx;
      pick_bit = t[0];
    end
  endfunction

  // Append one received bit so that the first bit received ends up in the
  // position it was sent from.
  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b);
    if (MSB_FIRST != 0) begin
      shift_in = {w[DATA_W-2:0], b};
    end else begin
      shift_in = {b, w[DATA_W-1:1]};
    end
  endfunction

  // Per-edge decode: which action the upcoming SCLK edge carries.
  // For both phases the bit driven on edge e is bit e/2 in send order.
  always_comb begin
    next_edge_s = edge_cnt_r + EDGE_W'(1);
    drive_idx_s = int'(next_edge_s >> 1);
    drive_bit_s = pick_bit(tx_r, drive_idx_s);
    first_bit_s = pick_bit(tx_data, 0);
    if (CPHA == 0) begin
      sample_now_s = next_edge_s[0];
      drive_now_s  = ~next_edge_s[0] & (next_edge_s != EDGE_LAST);
    end else begin
      sample_now_s = ~next_edge_s[0];
      drive_now_s  = next_edge_s[0];
    end
`ifdef SPI_MASTER_LOOPBACK_EN
    if (loopback) begin
      rx_in_s = mosi;
    end else begin
      rx_in_s = miso;
    end
`else
    rx_in_s = miso;
`endif
  end

  // Transfer FSM with all pin-level outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      div_cnt_r  <= DIV_W'(0);
      edge_cnt_r <= EDGE_W'(0);
      tx_r       <= DATA_W'(0);
      rx_r       <= DATA_W'(0);
      cont_r     <= 1'b0;
      sclk       <= IDLE_SCLK;
      mosi       <= 1'b0;
      cs_n       <= 1'b1;
      busy       <= 1'b0;
      finish     <= 1'b0;
      rx_data    <= DATA_W'(0);
    end else begin
      finish <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            tx_r       <= tx_data;
            cont_r     <= cont;
            div_cnt_r  <= DIV_W'(0);
            edge_cnt_r <= EDGE_W'(0);
            cs_n       <= 1'b0;
            busy       <= 1'b1;
            state_r    <= SETUP;
            if (CPHA == 0) mosi <= first_bit_s;
          end
        end
        // SETUP is the idle half-period before edge 1; SHIFT then produces
        // one SCLK edge every CLK_DIV cycles starting on its entry.
        SETUP, SHIFT: begin
          if (div_cnt_r != DIV_LAST) begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
          end else begin
            div_cnt_r <= DIV_W'(0);
            if (edge_cnt_r == EDGE_LAST) begin
              state_r <= HOLD;
            end else begin
              state_r    <= SHIFT;
              sclk       <= ~sclk;
              edge_cnt_r <= next_edge_s;
              if (sample_now_s) rx_r <= shift_in(rx_r, rx_in_s);
              if (drive_now_s)  mosi <= drive_bit_s;
            end
          end
        end
        HOLD: begin
          if (div_cnt_r != DIV_LAST) begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
          end else begin
            div_cnt_r <= DIV_W'(0);
            rx_data   <= rx_r;
            finish    <= 1'b1;
            if (cont_r) begin
              state_r <= WAIT;
              busy    <= 1'b0;
            end else begin
              state_r <= TEARDOWN;
              cs_n    <= 1'b1;
            end
          end
        end
        // The first WAIT cycle coincides with finish; a start seen there is
        // ignored, so the decision is taken one cycle later.
        WAIT: begin
          if (finish) begin
            state_r <= WAIT;
          end else if (start) begin
            tx_r       <= tx_data;
            cont_r     <= cont;
            div_cnt_r  <= DIV_W'(0);
            edge_cnt_r <= EDGE_W'(0);
            busy       <= 1'b1;
            state_r    <= SETUP;
            if (CPHA == 0) mosi <= first_bit_s;
          end else begin
            div_cnt_r <= DIV_W'(0);
            cs_n      <= 1'b1;
            busy      <= 1'b1;
            state_r   <= TEARDOWN;
          end
        end
        TEARDOWN: begin
          if (div_cnt_r != DIV_LAST) begin
            div_cnt_r <= div_cnt_r + DIV_W'(1);
          end else begin
            div_cnt_r <= DIV_W'(0);
            busy      <= 1'b0;
            mosi      <= 1'b0;
            state_r   <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          cs_n    <= 1'b1;
          busy    <= 1'b0;
          sclk    <= IDLE_SCLK;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_param.sv
// -----------------------------------------------------------------------------
// tb_spi_master_param
//   Three masters: u0 default (mode 0, MSB first), u1 CPOL=1/CPHA=1/LSB first,
//   u2 DATA_W=16, CLK_DIV=2 with its mosi looped back to the receive side.
//   Behavioural slaves return queued words and record the mosi bit stream.
// -----------------------------------------------------------------------------
module tb_spi_master_param;

  localparam int LIM   = 400;
  localparam int LAT8  = (2*8+2)*4+1;
  localparam int LAT16 = (2*16+2)*2+1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic        start0 = 1'b0, cont0 = 1'b0, miso0 = 1'b0;
  logic [7:0]  tx0 = 8'h00, rx0;
  logic        sclk0, mosi0, cs_n0, busy0, finish0;
  logic        start1 = 1'b0, cont1 = 1'b0, miso1 = 1'b0;
  logic [7:0]  tx1 = 8'h00, rx1;
  logic        sclk1, mosi1, cs_n1, busy1, finish1;
  logic        start2 = 1'b0, cont2 = 1'b0, miso2;
  logic [15:0] tx2 = 16'h0000, rx2;
  logic        sclk2, mosi2, cs_n2, busy2, finish2;

`ifdef SPI_MASTER_LOOPBACK_EN
  // Inverted external return: only the internal loopback can give rx == tx.
  assign miso2 = ~mosi2;
`else
  assign miso2 = mosi2;
`endif

  spi_master_param u0 (
    .clk(clk), .rst(rst), .start(start0), .cont(cont0), .tx_data(tx0), .miso(miso0),
`ifdef SPI_MASTER_LOOPBACK_EN
    .loopback(1'b0),
`endif
    .sclk(sclk0), .mosi(mosi0), .cs_n(cs_n0), .busy(busy0), .finish(finish0), .rx_data(rx0));

  spi_master_param #(.CPOL(1), .CPHA(1), .MSB_FIRST(0)) u1 (
    .clk(clk), .rst(rst), .start(start1), .cont(cont1), .tx_data(tx1), .miso(miso1),
`ifdef SPI_MASTER_LOOPBACK_EN
    .loopback(1'b0),
`endif
    .sclk(sclk1), .mosi(mosi1), .cs_n(cs_n1), .busy(busy1), .finish(finish1), .rx_data(rx1));

  spi_master_param #(.CLK_DIV(2), .DATA_W(16)) u2 (
    .clk(clk), .rst(rst), .start(start2), .cont(cont2), .tx_data(tx2), .miso(miso2),
`ifdef SPI_MASTER_LOOPBACK_EN
    .loopback(1'b1),
`endif
    .sclk(sclk2), .mosi(mosi2), .cs_n(cs_n2), .busy(busy2), .finish(finish2), .rx_data(rx2));

  // Bit i of a word in transmission order.
  function automatic logic bitof(input logic [31:0] w, input int i, input int dw, input bit msb);
    logic [31:0] t;
    t = msb ? (w >> (dw-1-i)) : (w >> i);
    return t[0];
  endfunction

  // Mode-0 MSB-first slave for u0; also flags mosi changes not on falling sclk.
  logic [7:0] sq0[$];
  logic       cq0[$];
  logic [7:0] sw0 = 8'h00;
  int         sk0 = 0, sec0 = 0, fc0 = 0, ev0 = 0;
  bit         chk_en = 1'b0;
  logic       ps0 = 1'b0, pcs0 = 1'b1, pm0 = 1'b0;

  always @(negedge clk) begin
    if (rst || cs_n0 === 1'b1) begin
      sk0 = 0; sec0 = 0;
    end else begin
      if (pcs0 === 1'b1) begin
        sw0 = (sq0.size() > 0) ? sq0.pop_front() : 8'h00;
        miso0 = bitof({24'h0, sw0}, 0, 8, 1'b1); sk0 = 1; sec0 = 0;
      end
      if (sclk0 !== ps0) begin
        sec0++;
        if (sclk0 === 1'b1) cq0.push_back(mosi0);
        else if (sk0 < 8) begin miso0 = bitof({24'h0, sw0}, sk0, 8, 1'b1); sk0++; end
        if (sec0 == 16) begin
          sec0 = 0;
          if (sq0.size() > 0) begin
            sw0 = sq0.pop_front(); miso0 = bitof({24'h0, sw0}, 0, 8, 1'b1); sk0 = 1;
          end
        end
      end
      if (chk_en && pcs0 === 1'b0 && mosi0 !== pm0 && !(ps0 === 1'b1 && sclk0 === 1'b0)) ev0++;
    end
    if (finish0 === 1'b1) fc0++;
    ps0 = sclk0; pcs0 = cs_n0; pm0 = mosi0;
  end

  // Mode-3 LSB-first slave for u1: drives on falling (leading), samples rising.
  logic [7:0] sq1[$];
  logic       cq1[$];
  logic [7:0] sw1 = 8'h00;
  int         sk1 = 0, fc1 = 0;
  logic       ps1 = 1'b1, pcs1 = 1'b1;

  always @(negedge clk) begin
    if (rst || cs_n1 === 1'b1) begin
      sk1 = 0;
    end else begin
      if (pcs1 === 1'b1) sw1 = (sq1.size() > 0) ? sq1.pop_front() : 8'h00;
      if (sclk1 !== ps1) begin
        if (sclk1 === 1'b0) begin miso1 = bitof({24'h0, sw1}, sk1, 8, 1'b0); sk1++; end
        else cq1.push_back(mosi1);
      end
    end
    if (finish1 === 1'b1) fc1++;
    ps1 = sclk1; pcs1 = cs_n1;
  end

  // Start one word on u0, optionally inject a stray start at cycle 'inj';
  // returns cycles to finish (-1 on timeout) and cycles with cs_n high.
  task automatic go0(input logic [7:0] tx, input logic c, input int inj, output int cyc, output int csh);
    @(negedge clk); tx0 = tx; cont0 = c; start0 = 1'b1;
    @(negedge clk); start0 = 1'b0; cont0 = 1'b0; cyc = 1; csh = 0;
    while (finish0 !== 1'b1 && cyc < LIM) begin
      if (cs_n0 !== 1'b0) csh++;
      if (cyc == inj) begin start0 = 1'b1; tx0 = ~tx; cont0 = 1'b1; end
      else start0 = 1'b0;
      @(negedge clk); cyc++;
    end
    start0 = 1'b0; cont0 = 1'b0;
    if (finish0 !== 1'b1) cyc = -1;
  endtask

  task automatic go1(input logic [7:0] tx, output int cyc);
    @(negedge clk); tx1 = tx; cont1 = 1'b0; start1 = 1'b1;
    @(negedge clk); start1 = 1'b0; cyc = 1;
    while (finish1 !== 1'b1 && cyc < LIM) begin @(negedge clk); cyc++; end
    if (finish1 !== 1'b1) cyc = -1;
  endtask

  task automatic go2(input logic [15:0] tx, output int cyc);
    @(negedge clk); tx2 = tx; cont2 = 1'b0; start2 = 1'b1;
    @(negedge clk); start2 = 1'b0; cyc = 1;
    while (finish2 !== 1'b1 && cyc < LIM) begin @(negedge clk); cyc++; end
    if (finish2 !== 1'b1) cyc = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({sclk0, mosi0, cs_n0, busy0, finish0, rx0} !== {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
      miscompares++;
      $display("FAIL reset_u0: got sclk/mosi/cs_n/busy/finish=%b%b%b%b%b rx=%h want 00100 rx=00",
               sclk0, mosi0, cs_n0, busy0, finish0, rx0);
    end
    vectors++;
    if ({sclk1, cs_n1, busy1, rx1} !== {1'b1, 1'b1, 1'b0, 8'h00}) begin
      miscompares++;
      $display("FAIL reset_u1: got sclk=%b cs_n=%b busy=%b rx=%h want sclk=1 cs_n=1 busy=0 rx=00",
               sclk1, cs_n1, busy1, rx1);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int cyc, csh;
    logic [7:0] capw;
    sq0.push_back(8'hFF); cq0.delete(); ev0 = 0; fc0 = 0; chk_en = 1'b1;
    go0(8'hB7, 1'b0, 0, cyc, csh);
    vectors++;
    if (cyc !== LAT8) begin miscompares++; $display("FAIL basic_latency: got %0d want %0d", cyc, LAT8); end
    vectors++;
    if (rx0 !== 8'hFF) begin miscompares++; $display("FAIL basic_rx: got %h want ff", rx0); end
    vectors++;
    if (csh !== 0) begin miscompares++; $display("FAIL basic_cs_low: cs_n high %0d cycles want 0", csh); end
    capw = 8'h00;
    foreach (cq0[i]) capw = {capw[6:0], cq0[i]};
    vectors++;
    if (cq0.size() !== 8 || capw !== 8'b1011_0111) begin
      miscompares++; $display("FAIL basic_mosi: got %0d bits %b want 8 bits 10110111", cq0.size(), capw);
    end
    repeat (4) @(negedge clk);
    chk_en = 1'b0;
    vectors++;
    if (ev0 !== 0) begin miscompares++; $display("FAIL basic_mosi_edge: %0d changes off falling sclk want 0", ev0); end
    vectors++;
    if ({cs_n0, busy0, mosi0} !== 3'b100 || fc0 !== 1) begin
      miscompares++; $display("FAIL basic_after: cs_n/busy/mosi=%b%b%b finishes=%0d want 100 and 1",
                              cs_n0, busy0, mosi0, fc0);
    end
  endtask

  task automatic test_random();
    int cyc, csh;
    logic [7:0] t, s, capw;
    for (int n = 0; n < 5; n++) begin
      t = 8'($urandom); s = 8'($urandom);
      sq0.push_back(s); cq0.delete(); ev0 = 0; chk_en = 1'b1;
      go0(t, 1'b0, 0, cyc, csh);
      capw = 8'h00;
      foreach (cq0[i]) capw = {capw[6:0], cq0[i]};
      vectors++;
      if (cyc !== LAT8 || rx0 !== s || capw !== t || csh !== 0 || ev0 !== 0) begin
        miscompares++;
        $display("FAIL random_%0d: lat=%0d rx=%h mosi=%h cs_hi=%0d edge_err=%0d want lat=%0d rx=%h mosi=%h 0 0",
                 n, cyc, rx0, capw, csh, ev0, LAT8, s, t);
      end
      chk_en = 1'b0;
      repeat (6) @(negedge clk);
    end
  endtask

  task automatic test_modes();
    int cyc;
    logic [7:0] capw;
    vectors++;
    if (sclk1 !== 1'b1) begin miscompares++; $display("FAIL mode3_idle: sclk=%b want 1", sclk1); end
    sq1.push_back(8'h5A); cq1.delete();
    go1(8'hED, cyc);
    capw = 8'h00;
    foreach (cq1[i]) capw = {capw[6:0], cq1[i]};
    vectors++;
    if (cyc !== LAT8 || rx1 !== 8'h5A) begin
      miscompares++; $display("FAIL mode3_rx: lat=%0d rx=%h want lat=%0d rx=5a", cyc, rx1, LAT8);
    end
    vectors++;
    if (cq1.size() !== 8 || capw !== 8'b1011_0111) begin
      miscompares++; $display("FAIL mode3_mosi: got %0d bits %b want 8 bits 10110111", cq1.size(), capw);
    end
    repeat (6) @(negedge clk);
    vectors++;
    if ({sclk1, cs_n1, busy1} !== 3'b110) begin
      miscompares++; $display("FAIL mode3_after: sclk/cs_n/busy=%b%b%b want 110", sclk1, cs_n1, busy1);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, csh, cyc2, csh2, f0;
    logic [7:0] s1, s2;
    logic [15:0] capw;
    logic cs_at_fin, busy_at_fin;
    s1 = 8'($urandom); s2 = 8'($urandom);
    sq0.push_back(s1); sq0.push_back(s2); cq0.delete(); f0 = fc0;
    go0(8'h11, 1'b1, 0, cyc, csh);
    cs_at_fin = cs_n0; busy_at_fin = busy0;
    vectors++;
    if (cyc !== LAT8 || rx0 !== s1) begin
      miscompares++; $display("FAIL burst_w1: lat=%0d rx=%h want lat=%0d rx=%h", cyc, rx0, LAT8, s1);
    end
    vectors++;
    if ({cs_at_fin, busy_at_fin} !== 2'b00) begin
      miscompares++; $display("FAIL burst_wait: cs_n/busy=%b%b want 00", cs_at_fin, busy_at_fin);
    end
    go0(8'h22, 1'b0, 0, cyc2, csh2);
    vectors++;
    if (cyc2 !== LAT8 || rx0 !== s2 || csh + csh2 !== 0) begin
      miscompares++; $display("FAIL burst_w2: lat=%0d rx=%h cs_hi=%0d want lat=%0d rx=%h cs_hi=0",
                              cyc2, rx0, csh + csh2, LAT8, s2);
    end
    capw = 16'h0000;
    foreach (cq0[i]) capw = {capw[14:0], cq0[i]};
    vectors++;
    if (cq0.size() !== 16 || capw !== 16'h1122) begin
      miscompares++; $display("FAIL burst_mosi: got %0d bits %h want 16 bits 1122", cq0.size(), capw);
    end
    repeat (6) @(negedge clk);
    vectors++;
    if (cs_n0 !== 1'b1 || busy0 !== 1'b0 || fc0 - f0 !== 2) begin
      miscompares++; $display("FAIL burst_end: cs_n=%b busy=%b finishes=%0d want 1 0 2", cs_n0, busy0, fc0 - f0);
    end
  endtask

  task automatic test_ignore_start();
    int cyc, csh, f0;
    logic [7:0] t, s, capw;
    t = 8'($urandom); s = 8'($urandom);
    sq0.push_back(s); cq0.delete(); f0 = fc0;
    go0(t, 1'b0, 30, cyc, csh);
    capw = 8'h00;
    foreach (cq0[i]) capw = {capw[6:0], cq0[i]};
    vectors++;
    if (cyc !== LAT8 || rx0 !== s || capw !== t) begin
      miscompares++; $display("FAIL ignore_frame: lat=%0d rx=%h mosi=%h want lat=%0d rx=%h mosi=%h",
                              cyc, rx0, capw, LAT8, s, t);
    end
    repeat (12) @(negedge clk);
    vectors++;
    if (fc0 - f0 !== 1 || cs_n0 !== 1'b1 || busy0 !== 1'b0) begin
      miscompares++; $display("FAIL ignore_after: finishes=%0d cs_n=%b busy=%b want 1 1 0", fc0 - f0, cs_n0, busy0);
    end
  endtask

  task automatic test_reset_mid();
    int n, cyc, csh, f0, hi;
    logic [7:0] s;
    sq0.push_back(8'($urandom));
    @(negedge clk); tx0 = 8'($urandom); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0; n = 0;
    while (sec0 != 7 && n < LIM) begin @(negedge clk); n++; end
    vectors++;
    if (n >= LIM) begin miscompares++; $display("FAIL rstmid_reach: edge 7 not seen in %0d cycles", n); end
    f0 = fc0;
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({cs_n0, sclk0, busy0, finish0, mosi0, rx0} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      miscompares++;
      $display("FAIL rstmid_state: cs_n/sclk/busy/finish/mosi=%b%b%b%b%b rx=%h want 10000 rx=00",
               cs_n0, sclk0, busy0, finish0, mosi0, rx0);
    end
    rst = 1'b0; hi = 0;
    repeat (80) begin @(negedge clk); if (cs_n0 === 1'b1) hi++; end
    vectors++;
    if (fc0 !== f0 || hi !== 80) begin
      miscompares++; $display("FAIL rstmid_quiet: finishes=%0d cs_n high %0d/80 want 0 and 80", fc0 - f0, hi);
    end
    sq0.delete();
    s = 8'($urandom);
    sq0.push_back(s);
    go0(8'($urandom), 1'b0, 0, cyc, csh);
    vectors++;
    if (cyc !== LAT8 || rx0 !== s) begin
      miscompares++; $display("FAIL rstmid_restart: lat=%0d rx=%h want lat=%0d rx=%h", cyc, rx0, LAT8, s);
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_loopback();
    int cyc;
    logic [15:0] t;
    for (int n = 0; n < 3; n++) begin
      t = (n == 0) ? 16'hC3A5 : 16'($urandom);
      go2(t, cyc);
      vectors++;
      if (cyc !== LAT16 || rx2 !== t) begin
        miscompares++; $display("FAIL loopback_%0d: lat=%0d rx=%h want lat=%0d rx=%h", n, cyc, rx2, LAT16, t);
      end
      repeat (4) @(negedge clk);
      vectors++;
      if ({cs_n2, busy2, sclk2} !== 3'b100) begin
        miscompares++; $display("FAIL loopback_idle_%0d: cs_n/busy/sclk=%b%b%b want 100", n, cs_n2, busy2, sclk2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_modes();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    test_loopback();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
